// File: rtl/dfp_pkg.sv
// Shared types and default sizing for the deser_fifo_pipeline receive path.
`timescale 1ns/1ps
package dfp_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} des_state_t;

  localparam int DFP_W        = 8;
  localparam int DFP_DEPTH    = 4;
  localparam int DFP_DES_DIV  = 10;
  localparam int DFP_FIFO_DIV = 100;
endpackage

// File: rtl/dfp_tick_gen.sv
// Free-running divide-by-DIV counter producing a one-cycle clock-enable tick.
`timescale 1ns/1ps
module dfp_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clock_1MHz,
  input  logic rst,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clock_1MHz) begin
    if (rst) r_cnt <= '0;
    else if (r_cnt == CW'(DIV - 1)) r_cnt <= '0;
    else r_cnt <= r_cnt + CW'(1);
  end

  assign tick = (r_cnt == CW'(DIV - 1));
endmodule

// File: rtl/deser_fifo_pipeline.sv
// Serial-in, word-out receive path: MSB-first deserialiser handing words to a DEPTH-entry FIFO.
// Optional almost_full output is enabled by defining DFP_ALMOST_FULL_EN.
`timescale 1ns/1ps
module deser_fifo_pipeline
  import dfp_pkg::*;
#(
  parameter int W        = DFP_W,
  parameter int DEPTH    = DFP_DEPTH,
  parameter int DES_DIV  = DFP_DES_DIV,
  parameter int FIFO_DIV = DFP_FIFO_DIV
`ifdef DFP_ALMOST_FULL_EN
  ,
  parameter int AF_LEVEL = 3
`endif
) (
  input  logic                       clock_1MHz,
  input  logic                       rst,
  input  logic                       data_in,
  input  logic                       write_in,
  input  logic                       dequeue_in,
  output logic                       status_out,
  output logic [W-1:0]               data_out,
  output logic                       data_valid,
  output logic [$clog2(DEPTH+1)-1:0] len_out,
  output logic                       full,
  output logic                       empty
`ifdef DFP_ALMOST_FULL_EN
  ,
  output logic                       almost_full
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(W);

  logic              w_des_tick;
  logic              w_fifo_tick;
  logic              w_push;
  logic              w_pop;
  logic [W-1:0]      w_shift;
  logic [LW-1:0]     w_len_next;

  des_state_t        r_state;
  logic [W-2:0]      r_sr;
  logic [CW-1:0]     r_bit_cnt;
  logic [W-1:0]      r_hold;
  logic [W-1:0]      r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;

  dfp_tick_gen #(.DIV(DES_DIV)) u_des_tick (
    .clock_1MHz (clock_1MHz),
    .rst        (rst),
    .tick       (w_des_tick)
  );

  dfp_tick_gen #(.DIV(FIFO_DIV)) u_fifo_tick (
    .clock_1MHz (clock_1MHz),
    .rst        (rst),
    .tick       (w_fifo_tick)
  );

  assign full    = (len_out == LW'(DEPTH));
  assign empty   = (len_out == '0);
  assign w_shift = {r_sr, data_in};
  // full is the pre-pop value, so a full FIFO defers the push even when a pop frees a slot.
  assign w_push  = w_fifo_tick && (r_state == HOLD) && !full;
  assign w_pop   = w_fifo_tick && dequeue_in && !empty;

  always_comb begin
    w_len_next = len_out;
    if (w_push && !w_pop)      w_len_next = len_out + LW'(1);
    else if (!w_push && w_pop) w_len_next = len_out - LW'(1);
  end

  always_ff @(posedge clock_1MHz) begin
    if (rst) begin
      r_state    <= IDLE;
      r_sr       <= '0;
      r_bit_cnt  <= '0;
      r_hold     <= '0;
      status_out <= 1'b0;
    end else begin
      case (r_state)
        IDLE, SHIFT: begin
          if (w_des_tick && write_in) begin
            if (r_bit_cnt == CW'(W - 1)) begin
              r_hold     <= w_shift;
              r_bit_cnt  <= '0;
              r_state    <= HOLD;
              status_out <= 1'b1;
            end else begin
              r_sr      <= w_shift[W-2:0];
              r_bit_cnt <= r_bit_cnt + CW'(1);
              r_state   <= SHIFT;
            end
          end
        end
        HOLD: begin
          if (w_push) begin
            r_state    <= IDLE;
            status_out <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // NOTE: storage has no reset; an entry is only read after it has been written.
  always_ff @(posedge clock_1MHz) begin
    if (w_push) r_mem[r_wr_ptr] <= r_hold;
  end

  always_ff @(posedge clock_1MHz) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      len_out    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= w_pop;
      len_out    <= w_len_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) begin
        data_out <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

`ifdef DFP_ALMOST_FULL_EN
  always_ff @(posedge clock_1MHz) begin
    if (rst) almost_full <= 1'b0;
    else     almost_full <= (w_len_next >= LW'(AF_LEVEL));
  end
`endif
endmodule
